// File: rtl/multibank_arbiter.sv
// rtl/multibank_arbiter.sv - two-requester scheduler for the dual-port 4-bank memory controller
//
// Requester 0 is bound to memory port A, requester 1 to port B. Same-bank
// write conflicts are resolved round-robin. Reads that would hit a write
// still in flight are held off. Read data returns a fixed number of cycles
// after acceptance.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_reqN_valid/we/addr/wdata   requester N command (N = 0, 1)
//   o_reqN_ready                 command accepted when valid && ready
//   o_rspN_valid/rdata           registered read response for requester N
//   o_ena/o_wea/o_addra/o_dina   port A command, one-cycle enable pulse
//   i_douta                      port A read data (RD_LATENCY after o_ena)
//   o_enb/o_web/o_addrb/o_dinb   port B command
//   i_doutb                      port B read data
//   o_conflict_cnt               saturating count of stall cycles
module multibank_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_DEPTH = 32,
    parameter int RD_LATENCY    = 3,
    parameter int WR_LATENCY    = 3,
    localparam int AW           = $clog2(ADDRESS_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0_valid,
    input  logic                  i_req0_we,
    input  logic [AW-1:0]         i_req0_addr,
    input  logic [DATA_WIDTH-1:0] i_req0_wdata,
    output logic                  o_req0_ready,
    output logic                  o_rsp0_valid,
    output logic [DATA_WIDTH-1:0] o_rsp0_rdata,
    input  logic                  i_req1_valid,
    input  logic                  i_req1_we,
    input  logic [AW-1:0]         i_req1_addr,
    input  logic [DATA_WIDTH-1:0] i_req1_wdata,
    output logic                  o_req1_ready,
    output logic                  o_rsp1_valid,
    output logic [DATA_WIDTH-1:0] o_rsp1_rdata,
    output logic                  o_ena,
    output logic                  o_wea,
    output logic [AW-1:0]         o_addra,
    output logic [DATA_WIDTH-1:0] o_dina,
    input  logic [DATA_WIDTH-1:0] i_douta,
    output logic                  o_enb,
    output logic                  o_web,
    output logic [AW-1:0]         o_addrb,
    output logic [DATA_WIDTH-1:0] o_dinb,
    input  logic [DATA_WIDTH-1:0] i_doutb,
    output logic [15:0]           o_conflict_cnt
);

    // Write history: one stage per cycle of write latency, two slots per
    // stage so that writes accepted together on both ports are both tracked.
    logic [WR_LATENCY-1:0][1:0]         sb_vld;
    logic [WR_LATENCY-1:0][1:0][AW-1:0] sb_addr;

    logic [RD_LATENCY-1:0] rd_pipe0;
    logic [RD_LATENCY-1:0] rd_pipe1;

    logic rr;           // 0: requester 0 wins the next conflict
    logic sb_hit0;
    logic sb_hit1;
    logic hz0;
    logic hz1;
    logic c0;
    logic c1;
    logic conflict;
    logic acc0;
    logic acc1;
    logic stall;

    always_comb begin
        sb_hit0 = 1'b0;
        sb_hit1 = 1'b0;
        for (int s = 0; s < WR_LATENCY; s++) begin
            for (int k = 0; k < 2; k++) begin
                if (sb_vld[s][k] && (sb_addr[s][k] == i_req0_addr)) sb_hit0 = 1'b1;
                if (sb_vld[s][k] && (sb_addr[s][k] == i_req1_addr)) sb_hit1 = 1'b1;
            end
        end
    end

    // A read is also hazarded by a write to the same word offered by the
    // other requester in this very cycle, since that write is not yet in
    // the history.
    assign hz0 = !i_req0_we && (sb_hit0 ||
                 (i_req1_valid && i_req1_we && (i_req1_addr == i_req0_addr)));
    assign hz1 = !i_req1_we && (sb_hit1 ||
                 (i_req0_valid && i_req0_we && (i_req0_addr == i_req1_addr)));

    assign c0 = i_req0_valid && !hz0;
    assign c1 = i_req1_valid && !hz1;

    // Two reads to one bank go out on separate ports and are both allowed.
    assign conflict = c0 && c1 &&
                      (i_req0_addr[AW-1:AW-2] == i_req1_addr[AW-1:AW-2]) &&
                      (i_req0_we || i_req1_we);

    assign o_req0_ready = !i_rst && (conflict ? (rr == 1'b0) : c0);
    assign o_req1_ready = !i_rst && (conflict ? (rr == 1'b1) : c1);

    assign acc0  = i_req0_valid && o_req0_ready;
    assign acc1  = i_req1_valid && o_req1_ready;
    assign stall = (i_req0_valid && !o_req0_ready) || (i_req1_valid && !o_req1_ready);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr             <= 1'b0;
            o_ena          <= 1'b0;
            o_wea          <= 1'b0;
            o_addra        <= '0;
            o_dina         <= '0;
            o_enb          <= 1'b0;
            o_web          <= 1'b0;
            o_addrb        <= '0;
            o_dinb         <= '0;
            sb_vld         <= '0;
            sb_addr        <= '0;
            rd_pipe0       <= '0;
            rd_pipe1       <= '0;
            o_rsp0_valid   <= 1'b0;
            o_rsp0_rdata   <= '0;
            o_rsp1_valid   <= 1'b0;
            o_rsp1_rdata   <= '0;
            o_conflict_cnt <= '0;
        end else begin
            if (conflict) rr <= ~rr;

            o_ena <= acc0;
            o_wea <= acc0 && i_req0_we;
            if (acc0) begin
                o_addra <= i_req0_addr;
                o_dina  <= i_req0_wdata;
            end

            o_enb <= acc1;
            o_web <= acc1 && i_req1_we;
            if (acc1) begin
                o_addrb <= i_req1_addr;
                o_dinb  <= i_req1_wdata;
            end

            // Writes enter the history at acceptance so a read offered on
            // the very next cycle already sees them.
            for (int s = WR_LATENCY - 1; s > 0; s--) begin
                sb_vld[s]  <= sb_vld[s-1];
                sb_addr[s] <= sb_addr[s-1];
            end
            sb_vld[0]     <= {acc1 && i_req1_we, acc0 && i_req0_we};
            sb_addr[0][0] <= i_req0_addr;
            sb_addr[0][1] <= i_req1_addr;

            // Pipe bits start when the read is on the port, so they emerge
            // in the cycle the memory data is valid.
            rd_pipe0 <= (rd_pipe0 << 1) | {{(RD_LATENCY-1){1'b0}}, o_ena && !o_wea};
            rd_pipe1 <= (rd_pipe1 << 1) | {{(RD_LATENCY-1){1'b0}}, o_enb && !o_web};

            o_rsp0_valid <= rd_pipe0[RD_LATENCY-1];
            if (rd_pipe0[RD_LATENCY-1]) o_rsp0_rdata <= i_douta;
            o_rsp1_valid <= rd_pipe1[RD_LATENCY-1];
            if (rd_pipe1[RD_LATENCY-1]) o_rsp1_rdata <= i_doutb;

            if (stall && (o_conflict_cnt != 16'hFFFF))
                o_conflict_cnt <= o_conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_multibank_arbiter.sv
// tb/tb_multibank_arbiter.sv - directed self-checking bench for multibank_arbiter
module tb_multibank_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_we, req0_ready, rsp0_valid;
    logic [4:0] req0_addr;
    logic [7:0] req0_wdata, rsp0_rdata;
    logic       req1_valid, req1_we, req1_ready, rsp1_valid;
    logic [4:0] req1_addr;
    logic [7:0] req1_wdata, rsp1_rdata;
    logic       ena, wea, enb, web;
    logic [4:0] addra, addrb;
    logic [7:0] dina, dinb, douta, doutb;
    logic [15:0] conflict_cnt;

    int checks;
    int failures;

    multibank_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(req0_valid), .i_req0_we(req0_we), .i_req0_addr(req0_addr),
        .i_req0_wdata(req0_wdata), .o_req0_ready(req0_ready),
        .o_rsp0_valid(rsp0_valid), .o_rsp0_rdata(rsp0_rdata),
        .i_req1_valid(req1_valid), .i_req1_we(req1_we), .i_req1_addr(req1_addr),
        .i_req1_wdata(req1_wdata), .o_req1_ready(req1_ready),
        .o_rsp1_valid(rsp1_valid), .o_rsp1_rdata(rsp1_rdata),
        .o_ena(ena), .o_wea(wea), .o_addra(addra), .o_dina(dina), .i_douta(douta),
        .o_enb(enb), .o_web(web), .o_addrb(addrb), .o_dinb(dinb), .i_doutb(doutb),
        .o_conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data valid three cycles after the enable is seen.
    logic [7:0] mem [32];
    logic [7:0] pa1, pa2, pb1, pb2;
    always @(posedge clk) begin
        if (ena) begin
            if (wea) mem[addra] <= dina;
            else     pa1 <= mem[addra];
        end
        if (enb) begin
            if (web) mem[addrb] <= dinb;
            else     pb1 <= mem[addrb];
        end
        pa2 <= pa1; douta <= pa2;
        pb2 <= pb1; doutb <= pb2;
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic set0(input logic we, input logic [4:0] a, input logic [7:0] d);
        req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
    endtask

    task automatic set1(input logic we, input logic [4:0] a, input logic [7:0] d);
        req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        douta = '0; doutb = '0; pa1 = '0; pa2 = '0; pb1 = '0; pb2 = '0;
        set0(1'b1, 5'h08, 8'h11);
        set1(1'b1, 5'h0C, 8'h22);
        #12;
        // reset state
        chk("rst_ena", ena, 0);
        chk("rst_enb", enb, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp0", rsp0_valid, 0);
        chk("rst_cnt", conflict_cnt, 0);
        idle();
        tick();
        rst = 1'b0;

        // different banks, both write
        set0(1'b1, 5'h03, 8'h5A);
        set1(1'b1, 5'h1B, 8'hA5);
        #1;
        chk("a_ready0", req0_ready, 1);
        chk("a_ready1", req1_ready, 1);
        tick();
        idle();
        chk("a_ena", ena, 1);
        chk("a_wea", wea, 1);
        chk("a_addra", addra, 5'h03);
        chk("a_dina", dina, 8'h5A);
        chk("a_enb", enb, 1);
        chk("a_addrb", addrb, 5'h1B);
        chk("a_dinb", dinb, 8'hA5);
        chk("a_cnt", conflict_cnt, 0);
        tick();
        chk("a_ena_low", ena, 0);
        chk("a_addra_hold", addra, 5'h03);

        // same-bank write conflict, round-robin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set0(1'b1, 5'h08, 8'h11);
        set1(1'b1, 5'h0C, 8'h22);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("b_ready0", req0_ready, (i % 2) == 0);
            chk("b_ready1", req1_ready, (i % 2) == 1);
            tick();
        end
        idle();
        chk("b_cnt", conflict_cnt, 4);
        chk("b_ena", ena, 0);
        chk("b_enb", enb, 1);
        chk("b_dinb", dinb, 8'h22);

        // read-after-write hazard
        set1(1'b1, 5'h10, 8'h77);
        #1;
        chk("c_ready1", req1_ready, 1);
        tick();
        idle();
        set0(1'b0, 5'h10, 8'h00);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("c_ready0", req0_ready, i == 3);
            tick();
        end
        idle();
        for (int i = 1; i <= 5; i++) begin
            chk("c_rsp0_valid", rsp0_valid, i == 5);
            if (i == 5) chk("c_rsp0_rdata", rsp0_rdata, 8'h77);
            else tick();
        end
        tick();
        chk("c_rsp0_pulse", rsp0_valid, 0);
        chk("c_cnt", conflict_cnt, 7);

        // two reads to one bank
        set0(1'b1, 5'h11, 8'h3C);
        #1;
        chk("d_wr0_ready", req0_ready, 1);
        tick();
        idle();
        set1(1'b1, 5'h15, 8'hC3);
        #1;
        chk("d_wr1_ready", req1_ready, 1);
        tick();
        idle();
        repeat (3) tick();
        set0(1'b0, 5'h11, 8'h00);
        set1(1'b0, 5'h15, 8'h00);
        #1;
        chk("d_ready0", req0_ready, 1);
        chk("d_ready1", req1_ready, 1);
        tick();
        idle();
        chk("d_ena", ena, 1);
        chk("d_wea", wea, 0);
        chk("d_enb", enb, 1);
        chk("d_web", web, 0);
        for (int i = 1; i <= 5; i++) begin
            chk("d_rsp0_valid", rsp0_valid, i == 5);
            chk("d_rsp1_valid", rsp1_valid, i == 5);
            if (i == 5) begin
                chk("d_rsp0_rdata", rsp0_rdata, 8'h3C);
                chk("d_rsp1_rdata", rsp1_rdata, 8'hC3);
            end else begin
                tick();
            end
        end
        chk("d_cnt", conflict_cnt, 7);

        // reset with a read in flight
        tick();
        set0(1'b0, 5'h03, 8'h00);
        #1;
        chk("e_ready0", req0_ready, 1);
        tick();
        idle();
        chk("e_ena", ena, 1);
        tick();
        rst = 1'b1;
        set0(1'b1, 5'h08, 8'h11);
        set1(1'b1, 5'h0C, 8'h22);
        #1;
        chk("e_rst_ena", ena, 0);
        chk("e_rst_addra", addra, 0);
        chk("e_rst_dina", dina, 0);
        chk("e_rst_enb", enb, 0);
        chk("e_rst_rsp0", rsp0_valid, 0);
        chk("e_rst_rdata0", rsp0_rdata, 0);
        chk("e_rst_cnt", conflict_cnt, 0);
        chk("e_rst_ready0", req0_ready, 0);
        chk("e_rst_ready1", req1_ready, 0);
        idle();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("e_no_rsp0", rsp0_valid, 0);
            tick();
        end
        set0(1'b1, 5'h08, 8'h11);
        set1(1'b1, 5'h0C, 8'h22);
        #1;
        chk("e_rr_ready0", req0_ready, 1);
        chk("e_rr_ready1", req1_ready, 0);

        // saturation of the stall counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (65534) tick();
        chk("f_cnt_fffe", conflict_cnt, 16'hFFFE);
        repeat (4466) tick();
        chk("f_cnt_sat", conflict_cnt, 16'hFFFF);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
